// File: rtl/frame_rx.sv
// Serial frame receiver: hunts for a sync word, collects payload bytes and
// verifies an 8-bit additive checksum, then tracks lock across frames.
module frame_rx #(
  parameter logic [7:0]  SYNC_WORD     = 8'h7E,
  parameter int unsigned PAYLOAD_BYTES = 4
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       bit_en,
  input  logic       rx_bit,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       locked
);

  localparam int unsigned BYTE_CNT_W = 4;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, SYNC_CHK} state_t;

  state_t                state, state_n;
  logic [7:0]            shreg, shreg_n;
  logic [2:0]            bit_cnt, bit_cnt_n;
  logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_n;
  logic [7:0]            acc, acc_n;
  logic                  primed, primed_n;
  logic [7:0]            data_out_n;
  logic                  data_valid_n, frame_ok_n, frame_err_n, locked_n;

  logic [7:0] shift_c;
  logic       byte_done_c;

  assign shift_c     = {shreg[6:0], rx_bit};
  assign byte_done_c = (bit_cnt == 3'd7);

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      byte_cnt   <= '0;
      acc        <= 8'h00;
      primed     <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      byte_cnt   <= byte_cnt_n;
      acc        <= acc_n;
      primed     <= primed_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      frame_ok   <= frame_ok_n;
      frame_err  <= frame_err_n;
      locked     <= locked_n;
    end
  end

  // Next-state and output logic; nothing moves without a bit strobe
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    byte_cnt_n   = byte_cnt;
    acc_n        = acc;
    primed_n     = primed;
    data_out_n   = data_out;
    data_valid_n = 1'b0;
    frame_ok_n   = 1'b0;
    frame_err_n  = 1'b0;
    locked_n     = locked;

    if (bit_en) begin
      shreg_n   = shift_c;
      bit_cnt_n = bit_cnt + 3'd1;

      unique case (state)
        HUNT: begin
          // A match needs eight real bits since the last clear, never stale zeros
          if (byte_done_c) primed_n = 1'b1;
          if ((primed || byte_done_c) && shift_c == SYNC_WORD) begin
            state_n    = PAYLOAD;
            bit_cnt_n  = 3'd0;
            byte_cnt_n = '0;
            acc_n      = 8'h00;
          end
        end

        PAYLOAD: begin
          if (byte_done_c) begin
            data_out_n   = shift_c;
            data_valid_n = 1'b1;
            acc_n        = acc + shift_c;
            if (byte_cnt == LAST_BYTE) begin
              state_n    = CHECK;
              byte_cnt_n = '0;
            end else begin
              byte_cnt_n = byte_cnt + BYTE_CNT_W'(1);
            end
          end
        end

        CHECK: begin
          if (byte_done_c) begin
            if (shift_c == acc) begin
              frame_ok_n = 1'b1;
              locked_n   = 1'b1;
              state_n    = SYNC_CHK;
            end else begin
              frame_err_n = 1'b1;
              locked_n    = 1'b0;
              shreg_n     = 8'h00;
              primed_n    = 1'b0;
              bit_cnt_n   = 3'd0;
              state_n     = HUNT;
            end
          end
        end

        SYNC_CHK: begin
          if (byte_done_c) begin
            if (shift_c == SYNC_WORD) begin
              state_n    = PAYLOAD;
              bit_cnt_n  = 3'd0;
              byte_cnt_n = '0;
              acc_n      = 8'h00;
            end else begin
              frame_err_n = 1'b1;
              locked_n    = 1'b0;
              shreg_n     = 8'h00;
              primed_n    = 1'b0;
              bit_cnt_n   = 3'd0;
              state_n     = HUNT;
            end
          end
        end

        default: state_n = HUNT;
      endcase
    end
  end

endmodule
